// File: rtl/pc_fetch_unit.sv
// PC and instruction-register owner for the multi-cycle MIPS core: fetch handshake and next-PC load.
// Optional PC_ALIGN_CHECK_EN adds a sticky pc_misalign flag that rejects non-word-aligned PC loads.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_start,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   input  logic        pc_write,
   input  logic        pc_write_cond,
   input  logic        branch_taken,
   input  logic [1:0]  pc_src,
   input  logic [31:0] alu_result,
   input  logic [31:0] alu_out,
   input  logic [31:0] jaddr,
   output logic [31:0] pc,
   output logic [31:0] ir,
   output logic [25:0] ins_addr,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic        fetch_done,
`ifdef PC_ALIGN_CHECK_EN
   output logic        pc_misalign,
`endif
   output logic        busy
);

   // state  | meaning
   // S_IDLE | no fetch in flight; PC loads accepted here only
   // S_WAIT | mem_req high, waiting for mem_ready
   // S_DONE | IR holds the new instruction; fetch_done pulse
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t      state, state_next;
   logic [31:0] pc_sel;
   logic        load_en;
   logic        pc_load;
   logic        pc_load_ok;
   logic        fetch_ok;
   logic        fetch_accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (fetch_start && fetch_ok) state_next = S_WAIT;
         S_WAIT:  if (mem_ready) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      pc_sel = pc;
      case (pc_src)
         2'b00:   pc_sel = alu_result;
         2'b01:   pc_sel = alu_out;
         2'b10:   pc_sel = jaddr;
         default: pc_sel = pc;
      endcase
   end

   // pc_src=11 is reserved and behaves as "hold", so it never counts as a load
   assign load_en      = pc_write | (pc_write_cond & branch_taken);
   assign pc_load      = (state == S_IDLE) && load_en && (pc_src != 2'b11);
   assign fetch_accept = (state == S_WAIT) && mem_ready;

`ifdef PC_ALIGN_CHECK_EN
   assign pc_load_ok = pc_load && (pc_sel[1:0] == 2'b00);
   assign fetch_ok   = !pc_misalign;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   pc_misalign <= 1'b0;
      else if (pc_load && pc_sel[1:0] != 2'b00)  pc_misalign <= 1'b1;
   end
`else
   assign pc_load_ok = pc_load;
   assign fetch_ok   = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)               pc <= RESET_PC;
      else if (fetch_accept) pc <= pc + PC_STEP;
      else if (pc_load_ok)   pc <= pc_sel;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)               ir <= 32'h0000_0000;
      else if (fetch_accept) ir <= mem_rdata;
   end

   assign ins_addr   = ir[25:0];
   assign mem_req    = (state == S_WAIT);
   assign mem_addr   = pc;
   assign fetch_done = (state == S_DONE);
   assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed test-plan cases plus randomized traffic
// compared every cycle against a transaction-level model of the fetch/PC rules.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_start, mem_ready, pc_write, pc_write_cond, branch_taken;
   logic [1:0]  pc_src;
   logic [31:0] mem_rdata, alu_result, alu_out, jaddr;
   logic [31:0] pc, ir, mem_addr;
   logic [25:0] ins_addr;
   logic        mem_req, fetch_done, busy;
`ifdef PC_ALIGN_CHECK_EN
   logic        pc_misalign;
`endif

   int tests = 0;
   int fails = 0;

   // model: a fetch is either absent, outstanding at memory, or just completed
   logic [31:0] m_pc, m_ir;
   bit          m_outstanding, m_completed, m_mis;

   always #5 clk = ~clk;

   pc_fetch_unit dut (
      .clk(clk), .rst(rst), .fetch_start(fetch_start), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .branch_taken(branch_taken), .pc_src(pc_src), .alu_result(alu_result),
      .alu_out(alu_out), .jaddr(jaddr), .pc(pc), .ir(ir), .ins_addr(ins_addr),
      .mem_req(mem_req), .mem_addr(mem_addr), .fetch_done(fetch_done),
`ifdef PC_ALIGN_CHECK_EN
      .pc_misalign(pc_misalign),
`endif
      .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_ir = 32'h0;
      m_outstanding = 0; m_completed = 0; m_mis = 0;
   endtask

   task automatic model_edge();
      logic [31:0] v;
      bit go;
      if (rst) begin
         model_reset();
      end else if (m_outstanding) begin
         if (mem_ready) begin
            m_ir = mem_rdata;
            m_pc = m_pc + 32'd4;
            m_outstanding = 0;
            m_completed = 1;
         end
      end else if (m_completed) begin
         m_completed = 0;
      end else begin
         go = fetch_start && !m_mis;
         if ((pc_write || (pc_write_cond && branch_taken)) && pc_src != 2'd3) begin
            v = (pc_src == 2'd0) ? alu_result : (pc_src == 2'd1) ? alu_out : jaddr;
`ifdef PC_ALIGN_CHECK_EN
            if (v % 4 != 0) m_mis = 1;
            else            m_pc = v;
`else
            m_pc = v;
`endif
         end
         if (go) m_outstanding = 1;
      end
   endtask

   task automatic compare_all();
      chk("pc", pc, m_pc);
      chk("ir", ir, m_ir);
      chk("ins_addr", {6'b0, ins_addr}, {6'b0, m_ir[25:0]});
      chk("mem_req", {31'b0, mem_req}, {31'b0, m_outstanding});
      chk("mem_addr", mem_addr, m_pc);
      chk("fetch_done", {31'b0, fetch_done}, {31'b0, m_completed});
      chk("busy", {31'b0, busy}, {31'b0, (m_outstanding | m_completed)});
`ifdef PC_ALIGN_CHECK_EN
      chk("pc_misalign", {31'b0, pc_misalign}, {31'b0, m_mis});
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle_inputs();
      fetch_start = 0; mem_ready = 0; pc_write = 0; pc_write_cond = 0;
      branch_taken = 0; pc_src = 2'd0;
   endtask

   initial begin
      rst = 1; idle_inputs();
      mem_rdata = 0; alu_result = 0; alu_out = 0; jaddr = 0;
      model_reset();
      step(); step();
      chk("lit_reset_pc", pc, 32'h0);
      chk("lit_reset_ir", ir, 32'h0);
      chk("lit_reset_busy", {31'b0, busy}, 32'h0);

      // single fetch from reset
      rst = 0; fetch_start = 1; step();
      fetch_start = 0;
      chk("lit_req", {31'b0, mem_req}, 32'h1);
      chk("lit_addr0", mem_addr, 32'h0);
      mem_ready = 1; mem_rdata = 32'h0800_0010; step();
      mem_ready = 0;
      chk("lit_done", {31'b0, fetch_done}, 32'h1);
      chk("lit_ir", ir, 32'h0800_0010);
      chk("lit_ins_addr", {6'b0, ins_addr}, 32'h0000_0010);
      chk("lit_pc4", pc, 32'h4);
      step();
      chk("lit_done_low", {31'b0, fetch_done}, 32'h0);

      // jump load, then fetch from the new PC
      pc_write = 1; pc_src = 2'd2; jaddr = 32'h40; step();
      pc_write = 0;
      chk("lit_jump", pc, 32'h40);
      fetch_start = 1; step();
      fetch_start = 0;
      chk("lit_jump_addr", mem_addr, 32'h40);
      mem_ready = 1; mem_rdata = $urandom; step();
      mem_ready = 0; step();

      // conditional branch taken / not taken
      pc_write_cond = 1; pc_src = 2'd1; alu_out = 32'h100; branch_taken = 1; step();
      chk("lit_br_taken", pc, 32'h100);
      branch_taken = 0; alu_out = 32'h200; step();
      pc_write_cond = 0;
      chk("lit_br_not", pc, 32'h100);

      // memory wait with ignored pc_write pulses
      fetch_start = 1; step();
      fetch_start = 0;
      for (int i = 0; i < 5; i++) begin
         pc_write = ~pc_write; pc_src = 2'd0; alu_result = $urandom & 32'hFFFF_FFFC;
         step();
         chk("lit_wait_req", {31'b0, mem_req}, 32'h1);
         chk("lit_wait_pc", pc, 32'h100);
      end
      pc_write = 0; mem_ready = 1; step();
      mem_ready = 0;
      chk("lit_wait_done", pc, 32'h104);
      step();

      // load and fetch in the same cycle: fetch uses the loaded PC
      pc_write = 1; pc_src = 2'd0; alu_result = 32'hFFFF_FFFC; fetch_start = 1; step();
      pc_write = 0; fetch_start = 0;
      chk("lit_same_cycle", mem_addr, 32'hFFFF_FFFC);
      mem_ready = 1; step();
      mem_ready = 0;
      chk("lit_wrap", pc, 32'h0);
      step();

      // reset during WAIT
      fetch_start = 1; step();
      fetch_start = 0;
      rst = 1; #1;
      chk("lit_async_req", {31'b0, mem_req}, 32'h0);
      chk("lit_async_busy", {31'b0, busy}, 32'h0);
      model_reset();
      step();
      rst = 0; mem_ready = 1; mem_rdata = 32'hDEAD_BEEF; step();
      mem_ready = 0;
      chk("lit_late_ready", ir, 32'h0);

      // randomized traffic, word-aligned load values
      for (int i = 0; i < 2000; i++) begin
         rst           = ($urandom_range(0, 149) == 0);
         fetch_start   = ($urandom_range(0, 3) == 0);
         mem_ready     = ($urandom_range(0, 2) == 0);
         pc_write      = ($urandom_range(0, 7) == 0);
         pc_write_cond = ($urandom_range(0, 7) == 0);
         branch_taken  = $urandom_range(0, 1);
         pc_src        = 2'($urandom_range(0, 3));
         mem_rdata     = $urandom;
         alu_result    = $urandom & 32'hFFFF_FFFC;
         alu_out       = $urandom & 32'hFFFF_FFFC;
         jaddr         = $urandom & 32'hFFFF_FFFC;
         step();
      end

      // drain to IDLE, then misaligned load
      rst = 0; idle_inputs(); mem_ready = 1;
      step(); step(); step();
      mem_ready = 0;
      pc_write = 1; pc_src = 2'd0; alu_result = 32'h200; step();
      chk("lit_pre_align", pc, 32'h200);
      alu_result = 32'h42; step();
      pc_write = 0;
`ifdef PC_ALIGN_CHECK_EN
      chk("lit_align_pc", pc, 32'h200);
      chk("lit_align_flag", {31'b0, pc_misalign}, 32'h1);
      fetch_start = 1; step();
      fetch_start = 0;
      chk("lit_align_nofetch", {31'b0, busy}, 32'h0);
`else
      chk("lit_noalign_pc", pc, 32'h42);
      fetch_start = 1; step();
      fetch_start = 0;
      chk("lit_noalign_fetch", mem_addr, 32'h42);
`endif
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the architectural PC and the instruction register (IR) of the multi-cycle MIPS core.
- Runs the instruction-fetch handshake with instruction memory and loads the next PC from the control unit's PC-source selection (sequential, branch target, jump address).
- Sits directly upstream of the jump-address calculator: it drives that calculator with the PC and IR[25:0], and consumes the 32-bit jump address it returns.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- PC_STEP, 4: increment applied to the PC on each completed fetch.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- fetch_start  input  1  control requests one instruction fetch; single-cycle pulse.
- mem_ready  input  1  instruction memory: mem_rdata valid this cycle.
- mem_rdata  input  32  instruction word from memory.
- pc_write  input  1  unconditional PC load (jump, jr).
- pc_write_cond  input  1  conditional PC load (beq/bne).
- branch_taken  input  1  branch condition already resolved by the ALU path (zero flag or its inverse for bne).
- pc_src  input  2  next-PC select: 00 alu_result, 01 alu_out, 10 jaddr, 11 reserved.
- alu_result  input  32  combinational ALU output (PC+4 or a jr target).
- alu_out  input  32  registered ALU output (branch target).
- jaddr  input  32  jump address from the jump-address calculator.
- pc  output  32  current PC register.
- ir  output  32  instruction register.
- ins_addr  output  26  ir[25:0], fed to the jump-address calculator.
- mem_req  output  1  fetch request to instruction memory.
- mem_addr  output  32  fetch address; always equals pc.
- fetch_done  output  1  one-cycle pulse when the IR holds the new instruction.
- busy  output  1  high when the state is not IDLE.

Behaviour:
- Reset (asynchronous, immediate): pc=RESET_PC, ir=0, mem_req=0, fetch_done=0, busy=0, state=IDLE.
- States:
  - IDLE: on fetch_start, go to WAIT.
  - WAIT: mem_req=1, mem_addr=pc. On mem_ready: ir<=mem_rdata, pc<=pc+PC_STEP (mod 2^32, carry dropped), go to DONE. Without mem_ready, stay in WAIT indefinitely.
  - DONE: fetch_done=1 for exactly this cycle, then go to IDLE.
- Minimum fetch latency: fetch_start at cycle N; mem_req asserted at N+1; with mem_ready at N+1, fetch_done is high at N+2.
- PC load (IDLE only): load_en = pc_write | (pc_write_cond & branch_taken). On load_en, pc <= the mux selected by pc_src.
- pc_src=11 with load_en: pc holds its value (no change).
- pc_write or pc_write_cond in WAIT or DONE is ignored; pc and ir are never corrupted mid-fetch.
- fetch_start and load_en in the same IDLE cycle: both take effect. The PC loads the new value and the fetch proceeds from that new PC (mem_addr in WAIT shows the loaded value).
- fetch_start in WAIT or DONE is ignored; no queuing.
- mem_ready in IDLE or DONE is ignored; ir is unchanged.
- Wrap-around: pc=32'hFFFF_FFFC, completed fetch gives pc=32'h0000_0000.
- Reset mid-fetch: mem_req drops asynchronously and state returns to IDLE. A late mem_ready is ignored.
- ir changes only on a WAIT-state mem_ready; ins_addr tracks ir combinationally.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output pc_misalign (1 bit, reset 0).
  - Any PC load whose selected value has bits [1:0] != 0 is suppressed: pc keeps its old value and pc_misalign sets sticky.
  - pc_misalign clears only on rst.
  - fetch_start is ignored while pc_misalign=1.
- Undefined: no pc_misalign port; all loads are accepted unchecked and low bits pass through.

Test Plan:
- Reset then single fetch: rst pulse; fetch_start; mem_ready one cycle later with mem_rdata=32'h0800_0010 -> mem_addr=0, ir=32'h0800_0010, ins_addr=26'h000_0010, pc=4, fetch_done one cycle.
- Jump load: IDLE, pc_write=1, pc_src=10, jaddr=32'h0000_0040 -> pc=32'h0000_0040; the next fetch issues mem_addr=32'h0000_0040.
- Conditional branch: pc_write_cond=1, pc_src=01, alu_out=32'h100 -> pc=32'h100 with branch_taken=1; pc unchanged with branch_taken=0.
- Memory wait and ignored writes: mem_ready held low 5 cycles while pc_write=1 pulses -> mem_req stays high, pc is unchanged until mem_ready, then pc=old+4.
- Wrap and reset mid-fetch: pc=32'hFFFF_FFFC fetch completes -> pc=0. Assert rst during WAIT -> mem_req=0 immediately; a later mem_ready leaves ir=0.
- PC_ALIGN_CHECK_EN: pc_write, pc_src=00, alu_result=32'h0000_0042 -> pc unchanged, pc_misalign=1, subsequent fetch_start ignored.
